// File: rtl/snn_config_loader.sv
// -----------------------------------------------------------------------------
// snn_config_loader
//
// Byte-serial configuration loader for the three-layer spiking network.
// A host streams NUM_BYTES configuration bytes followed by one XOR checksum
// byte. The bytes are collected in a shadow register. The live weight and
// neuron-parameter buses are replaced atomically, and only when the checksum
// matches. This lets the network keep running on the previous configuration
// while a new one is being loaded.
//
// Ports
//   clk               in   1            system clock, rising edge
//   rst_n             in   1            asynchronous reset, active low
//   i_start           in   1            1-cycle pulse: begin / restart a load
//   i_data_in         in   8            configuration or checksum byte
//   i_data_valid      in   1            i_data_in valid this cycle
//   o_input_weights   out  WEIGHT_BITS  live weight bus
//   o_neuron_params   out  PARAM_BITS   live neuron-parameter bus
//   o_busy            out  1            high while loading or awaiting checksum
//   o_done            out  1            1-cycle pulse after a successful commit
//   o_err             out  1            sticky checksum-mismatch flag
//   o_cfg_valid       out  1            a configuration was committed since reset
// -----------------------------------------------------------------------------
module snn_config_loader #(
    parameter int WEIGHT_BITS = 216,
    parameter int PARAM_BITS  = 96
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [7:0]             i_data_in,
    input  logic                   i_data_valid,
    output logic [WEIGHT_BITS-1:0] o_input_weights,
    output logic [PARAM_BITS-1:0]  o_neuron_params,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_cfg_valid
);

    localparam int TOTAL_BITS = WEIGHT_BITS + PARAM_BITS;
    localparam int NUM_BYTES  = TOTAL_BITS / 8;
    localparam int CNT_W      = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // Running XOR checksum: fold one more byte into the accumulator.
    function automatic logic [7:0] f_xor_accum(input logic [7:0] acc, input logic [7:0] b);
        f_xor_accum = acc ^ b;
    endfunction

    state_t                  r_state,     w_state_nxt;
    logic [TOTAL_BITS-1:0]   r_shadow,    w_shadow_nxt;
    logic [CNT_W-1:0]        r_count,     w_count_nxt;
    logic [7:0]              r_accum,     w_accum_nxt;
    logic [WEIGHT_BITS-1:0]  r_weights,   w_weights_nxt;
    logic [PARAM_BITS-1:0]   r_params,    w_params_nxt;
    logic                    r_busy;
    logic                    r_done,      w_done_nxt;
    logic                    r_err,       w_err_nxt;
    logic                    r_cfg_valid, w_cfg_valid_nxt;

    // Next-state and next-value logic for the load sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_shadow_nxt    = r_shadow;
        w_count_nxt     = r_count;
        w_accum_nxt     = r_accum;
        w_weights_nxt   = r_weights;
        w_params_nxt    = r_params;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_err;
        w_cfg_valid_nxt = r_cfg_valid;

        if (i_start) begin
            // A start has priority over everything. Any byte presented in the
            // same cycle is dropped, and a partial load is thrown away.
            w_state_nxt  = S_LOAD;
            w_shadow_nxt = {TOTAL_BITS{1'b0}};
            w_count_nxt  = {CNT_W{1'b0}};
            w_accum_nxt  = 8'h00;
            w_err_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                S_LOAD: begin
                    if (i_data_valid) begin
                        // The first byte shifts up to the top of the weight bus.
                        w_shadow_nxt = {r_shadow[TOTAL_BITS-9:0], i_data_in};
                        w_accum_nxt  = f_xor_accum(r_accum, i_data_in);
                        if (r_count == LAST_IDX) begin
                            w_state_nxt = S_CHECK;
                        end else begin
                            w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
                S_CHECK: begin
                    if (i_data_valid) begin
                        w_state_nxt = S_IDLE;
                        if (i_data_in == r_accum) begin
                            w_weights_nxt   = r_shadow[TOTAL_BITS-1:PARAM_BITS];
                            w_params_nxt    = r_shadow[PARAM_BITS-1:0];
                            w_cfg_valid_nxt = 1'b1;
                            w_done_nxt      = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_CHECK;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, shadow, and live output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shadow    <= {TOTAL_BITS{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_accum     <= 8'h00;
            r_weights   <= {WEIGHT_BITS{1'b0}};
            r_params    <= {PARAM_BITS{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cfg_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_count     <= w_count_nxt;
            r_accum     <= w_accum_nxt;
            r_weights   <= w_weights_nxt;
            r_params    <= w_params_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_cfg_valid <= w_cfg_valid_nxt;
        end
    end

    assign o_input_weights = r_weights;
    assign o_neuron_params = r_params;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_cfg_valid     = r_cfg_valid;

endmodule
